pc_sequencer: RTL and testbench

//  Consumer end of the control-unit interface: takes decoded branch/jump/halt/memory

---
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 tb/tb_pc_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter and memory-request sequencer. Owns the PC, runs the
// fetch / memory-wait / halted sequence, and emits the retire strobe that
// gates register writeback in the datapath.
module pc_sequencer #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              BrEq,
  input  logic              BrNeq,
  input  logic              Jump,
  input  logic              Jal,
  input  logic              RegToPc,
  input  logic              Halt,
  input  logic              DatRead,
  input  logic              DatWrite,
  input  logic              zero,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jaddr,
  input  logic [WORD_W-1:0] rdat1,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              instr_done,
  output logic              halt
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] npc_q, npc_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  logic [WORD_W-1:0] pc_plus4_w;
  logic [WORD_W-1:0] br_off_w;
  logic [WORD_W-1:0] npc_w;
  logic              br_taken_w;
  logic              mem_op_w;

  assign pc_plus4_w = pc_q + 32'd4;
  assign br_off_w   = {{14{imm16[15]}}, imm16, 2'b00};
  // When both branch kinds decode, only the beq condition counts.
  assign br_taken_w = BrEq ? zero : (BrNeq & ~zero);
  assign mem_op_w   = DatRead | DatWrite;

  // Next-PC selection in priority order: jr, j/jal, taken branch, fall-through.
  always_comb begin
    npc_w = pc_plus4_w;
    if (RegToPc) begin
      npc_w = rdat1;
    end else if (Jump | Jal) begin
      npc_w = {pc_plus4_w[31:28], jaddr, 2'b00};
    end else if (br_taken_w) begin
      npc_w = pc_plus4_w + br_off_w;
    end
  end

  // State, PC and latched memory-op registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      npc_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state logic: retire, park for a data access, or halt.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      FETCH: begin
        if (ihit) begin
          if (Halt) begin
            state_d = HALTED;
          end else if (mem_op_w) begin
            state_d = MEMWAIT;
            npc_d   = npc_w;
            rd_d    = DatRead;
            wr_d    = DatWrite & ~DatRead;
          end else begin
            pc_d = npc_w;
          end
        end
      end
      MEMWAIT: begin
        if (dhit) begin
          state_d = FETCH;
          pc_d    = npc_q;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Output decode; reset forces every strobe low in the same cycle.
  always_comb begin
    iREN       = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    instr_done = 1'b0;
    halt       = 1'b0;
    if (!RST) begin
      unique case (state_q)
        FETCH: begin
          iREN       = 1'b1;
          instr_done = ihit & ~Halt & ~mem_op_w;
        end
        MEMWAIT: begin
          dREN       = rd_q;
          dWEN       = wr_q;
          instr_done = dhit;
        end
        HALTED: begin
          halt = 1'b1;
        end
        default: begin
          iREN = 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_w;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, BrEq, BrNeq, Jump, Jal, RegToPc, Halt;
  logic        DatRead, DatWrite, zero;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic [31:0] rdat1;
  logic [31:0] pc, pc_plus4;
  logic        iREN, dREN, dWEN, instr_done, halt;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_INIT(PC_INIT), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .BrEq(BrEq),
    .BrNeq(BrNeq), .Jump(Jump), .Jal(Jal), .RegToPc(RegToPc), .Halt(Halt),
    .DatRead(DatRead), .DatWrite(DatWrite), .zero(zero), .imm16(imm16),
    .jaddr(jaddr), .rdat1(rdat1), .pc(pc), .pc_plus4(pc_plus4),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .instr_done(instr_done),
    .halt(halt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid   = 1'b0;
  logic [31:0] m_pc      = PC_INIT;
  logic        m_halted  = 1'b0;
  logic        m_waiting = 1'b0;
  logic [31:0] m_ret_pc  = '0;
  logic        m_rd      = 1'b0;
  logic        m_wr      = 1'b0;

  function automatic logic [31:0] m_target(input logic [31:0] cur);
    logic [31:0] seq;
    int          off;
    logic        taken;
    seq = cur + 32'd4;
    if (RegToPc) return rdat1;
    if (Jump || Jal) return (seq & 32'hF000_0000) | ({6'b0, jaddr} * 32'd4);
    taken = BrEq ? zero : (BrNeq && !zero);
    off = int'($signed(imm16));
    if (taken) return seq + 32'(off * 4);
    return seq;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_valid   = 1'b1;
      m_pc      = PC_INIT;
      m_halted  = 1'b0;
      m_waiting = 1'b0;
      m_rd      = 1'b0;
      m_wr      = 1'b0;
    end else if (m_halted) begin
      m_pc = m_pc;
    end else if (m_waiting) begin
      if (dhit) begin
        m_pc      = m_ret_pc;
        m_waiting = 1'b0;
      end
    end else if (ihit) begin
      if (Halt) begin
        m_halted = 1'b1;
      end else if (DatRead || DatWrite) begin
        m_waiting = 1'b1;
        m_ret_pc  = m_target(m_pc);
        m_rd      = DatRead;
        m_wr      = DatWrite && !DatRead;
      end else begin
        m_pc = m_target(m_pc);
      end
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge CLK) begin
    logic e_iren, e_dren, e_dwen, e_done, e_halt;
    if (m_valid) begin
      e_iren = 0; e_dren = 0; e_dwen = 0; e_done = 0; e_halt = 0;
      if (!RST) begin
        if (m_halted) begin
          e_halt = 1;
        end else if (m_waiting) begin
          e_dren = m_rd;
          e_dwen = m_wr;
          e_done = dhit;
        end else begin
          e_iren = 1;
          e_done = ihit && !Halt && !DatRead && !DatWrite;
        end
      end
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("iREN", {31'b0, iREN}, {31'b0, e_iren});
      chk("dREN", {31'b0, dREN}, {31'b0, e_dren});
      chk("dWEN", {31'b0, dWEN}, {31'b0, e_dwen});
      chk("instr_done", {31'b0, instr_done}, {31'b0, e_done});
      chk("halt", {31'b0, halt}, {31'b0, e_halt});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clr();
    ihit = 0; dhit = 0; BrEq = 0; BrNeq = 0; Jump = 0; Jal = 0;
    RegToPc = 0; Halt = 0; DatRead = 0; DatWrite = 0; zero = 0;
    imm16 = '0; jaddr = '0; rdat1 = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1; clr();
    tick(); tick();
    #1 chk("rst_pc", pc, 32'h0);
    chk("rst_iren", {31'b0, iREN}, 32'h0);
    chk("rst_halt", {31'b0, halt}, 32'h0);

    // Sequential fetch
    RST = 0; ihit = 1;
    #1 chk("seq_done", {31'b0, instr_done}, 32'h1);
    tick(); chk("seq_pc1", pc, 32'h4);
    tick(); chk("seq_pc2", pc, 32'h8);
    tick(); chk("seq_pc3", pc, 32'hC);

    // Jump to 0x40, then beq back onto itself, then not taken
    Jump = 1; jaddr = 26'h10;
    tick(); chk("jump_pc", pc, 32'h40);
    clr(); ihit = 1; BrEq = 1; zero = 1; imm16 = 16'hFFFF;
    tick(); chk("beq_taken", pc, 32'h40);
    zero = 0;
    tick(); chk("beq_nottaken", pc, 32'h44);

    // jr beats j
    clr(); ihit = 1; RegToPc = 1; Jump = 1; rdat1 = 32'h1000_0010;
    tick(); chk("jr_pc", pc, 32'h1000_0010);

    // jal keeps upper nibble of pc+4
    clr(); ihit = 1; Jal = 1; jaddr = 26'h10;
    #1 chk("jal_link", pc_plus4, 32'h1000_0014);
    tick(); chk("jal_pc", pc, 32'h1000_0040);

    // bne taken; then beq&bne with zero=0 uses only the beq term
    clr(); ihit = 1; BrNeq = 1; zero = 0; imm16 = 16'h0002;
    tick(); chk("bne_taken", pc, 32'h1000_004C);
    BrEq = 1;
    tick(); chk("beq_bne", pc, 32'h1000_0050);

    // no ihit holds; dhit in FETCH ignored
    clr();
    tick(); chk("hold_pc", pc, 32'h1000_0050);
    dhit = 1;
    tick(); chk("dhit_fetch", pc, 32'h1000_0050);

    // Reset, advance to 8, load with 3-cycle wait
    clr(); RST = 1;
    tick(); RST = 0; ihit = 1;
    tick(); tick(); chk("pre_load_pc", pc, 32'h8);
    DatRead = 1;
    tick(); chk("load_hold", pc, 32'h8);
    clr(); ihit = 1;
    #1 chk("load_dren1", {31'b0, dREN}, 32'h1);
    chk("load_iren1", {31'b0, iREN}, 32'h0);
    tick(); chk("load_ihit_ign", pc, 32'h8);
    #1 chk("load_dren2", {31'b0, dREN}, 32'h1);
    tick(); clr(); dhit = 1;
    #1 chk("load_dren3", {31'b0, dREN}, 32'h1);
    chk("load_done", {31'b0, instr_done}, 32'h1);
    tick(); chk("load_pc", pc, 32'hC);

    // Read+write together is a read
    clr(); ihit = 1; DatRead = 1; DatWrite = 1;
    tick(); clr();
    #1 chk("rw_dren", {31'b0, dREN}, 32'h1);
    chk("rw_dwen", {31'b0, dWEN}, 32'h0);
    dhit = 1;
    tick(); chk("rw_pc", pc, 32'h10);

    // Reset while a store waits
    clr(); ihit = 1; DatWrite = 1;
    tick(); clr();
    #1 chk("st_dwen", {31'b0, dWEN}, 32'h1);
    RST = 1;
    #1 chk("st_rst_dwen", {31'b0, dWEN}, 32'h0);
    tick(); RST = 0;
    chk("st_rst_pc", pc, PC_INIT);
    #1 chk("st_rst_iren", {31'b0, iREN}, 32'h1);

    // Halt wins over a store, then stays frozen
    ihit = 1;
    tick(); chk("pre_halt_pc", pc, 32'h4);
    Halt = 1; DatWrite = 1;
    #1 chk("halt_nodone", {31'b0, instr_done}, 32'h0);
    tick(); clr(); ihit = 1; dhit = 1; DatRead = 1;
    for (int i = 0; i < 20; i++) begin
      #1 chk("halted", {31'b0, halt}, 32'h1);
      chk("halted_dwen", {31'b0, dWEN}, 32'h0);
      chk("halted_pc", pc, 32'h4);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
